// File: rtl/cross_bar_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_slave_mem
// Description : Word-addressed memory slave that terminates one slave port
//               of cross_bar. Answers the req/ack handshake after a
//               programmable number of wait states, commits writes on the
//               handshake edge and returns read data through a registered
//               response path.
//
// Parameters  : DATA_W      - data width of wdata/rdata
//               ADDR_W      - byte address width (top 2 bits = crossbar
//                             slave select, ignored here)
//               DEPTH       - number of DATA_W words (power of two, >= 2)
//               WAIT_STATES - cycles inserted before ack (0..15)
//
// Ports       : clk    - clock, all state on rising edge
//               rst    - asynchronous active-high reset
//               req    - request, held with addr/cmd/wdata until handshake
//               addr   - byte address, word index = addr[IDX_W+1:2]
//               cmd    - 1 = write, 0 = read
//               wdata  - write data
//               ack    - registered accept pulse (one cycle)
//               rdata  - registered read response
//               wr_cnt - write handshake count (CB_SLAVE_MEM_STATS_EN only)
//               rd_cnt - read handshake count  (CB_SLAVE_MEM_STATS_EN only)
//
// Options     : `define CB_SLAVE_MEM_STATS_EN to add wrapping 16-bit
//               write/read handshake counters and their output ports.
//
// Revision    : 1.0 - initial release
// ============================================================================
module cross_bar_slave_mem #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
`ifdef CB_SLAVE_MEM_STATS_EN
    ,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
`endif
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam bit         c_NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [3:0] c_CNT_LOAD = c_NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_ACK  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               r_ack;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [c_IDX_W-1:0] w_idx;
    logic               w_hs;
    logic               w_wr;
    logic               w_rd;
    logic               w_unused_addr;

    // Slave-select bits and byte offset carry no meaning inside the slave;
    // upper index bits alias modulo DEPTH.
    assign w_idx         = addr[c_IDX_W+1:2];
    assign w_unused_addr = ^{addr[ADDR_W-1:c_IDX_W+2], addr[1:0]};

    // A handshake is the edge that ends the ACK cycle while req is still up.
    assign w_hs = (r_state == c_ACK) && req;
    assign w_wr = w_hs && cmd;
    assign w_rd = w_hs && !cmd;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    if (c_NO_WAIT) begin
                        w_state_nxt = c_ACK;
                    end else begin
                        w_state_nxt = c_WAIT;
                        w_cnt_nxt   = c_CNT_LOAD;
                    end
                end
            end
            c_WAIT: begin
                // Master withdrew the request: abandon without any access.
                if (!req) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = c_ACK;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            c_ACK: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // ack is a registered copy of "now in ACK"; ACK always exits
            // to IDLE so this can never be high two cycles running.
            r_ack   <= (w_state_nxt == c_ACK);
            if (w_rd) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Storage is not reset. An asynchronous reset forces r_state out of ACK
    // immediately, so a write caught in flight never reaches the array.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= wdata;
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;

`ifdef CB_SLAVE_MEM_STATS_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_rd_cnt;

    // Free-running counters; natural 16-bit overflow gives the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= 16'd0;
            r_rd_cnt <= 16'd0;
        end else begin
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign wr_cnt = r_wr_cnt;
    assign rd_cnt = r_rd_cnt;
`endif

endmodule
`default_nettype wire
